// File: rtl/timer_regs_pkg.sv
// timer_regs_pkg: interval-timer register map, control bit positions and master FSM types
package timer_regs_pkg;

    localparam logic [2:0] TMR_STATUS   = 3'd0;
    localparam logic [2:0] TMR_CONTROL  = 3'd1;
    localparam logic [2:0] TMR_PERIOD_L = 3'd2;
    localparam logic [2:0] TMR_PERIOD_H = 3'd3;
    localparam logic [2:0] TMR_SNAP_L   = 3'd4;
    localparam logic [2:0] TMR_SNAP_H   = 3'd5;

    localparam int ITO   = 0;
    localparam int CONT  = 1;
    localparam int START = 2;
    localparam int STOP  = 3;

    typedef enum logic [1:0] {
        OP_START = 2'd0,
        OP_STOP  = 2'd1,
        OP_SNAP  = 2'd2,
        OP_RSVD  = 2'd3
    } cmd_op_t;

    typedef enum logic [3:0] {
        IDLE, WR_PL, WR_PH, WR_CTRL, WR_STOP, WR_SNAP,
        RD_SL, WAIT_SL, RD_SH, WAIT_SH, SNAP_DONE, CLR_ST, IRQ_HOLD
    } state_t;

endpackage

// File: rtl/timer_ctrl_master_if.sv
// timer_ctrl_master_if: Avalon-MM port between the timer master and the interval timer
interface timer_ctrl_master_if #(
    parameter int ADDR_W = 3
);
    logic [ADDR_W-1:0] address;
    logic              read;
    logic              write;
    logic [15:0]       writedata;
    logic [15:0]       readdata;
    logic              waitrequest;
    logic              readdatavalid;

    modport master (
        output address, read, write, writedata,
        input  readdata, waitrequest, readdatavalid
    );

    modport slave (
        input  address, read, write, writedata,
        output readdata, waitrequest, readdatavalid
    );
endinterface

// File: rtl/timer_ctrl_master.sv
// timer_ctrl_master: turns START/STOP/SNAPSHOT commands into timer register sequences and services timer_irq
module timer_ctrl_master
    import timer_regs_pkg::*;
#(
    parameter int CNT_W  = 16,
    parameter int ADDR_W = 3
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [1:0]           cmd_op,
    input  logic [31:0]          cmd_period,
    input  logic                 cmd_continuous,
    output logic                 snap_valid,
    output logic [31:0]          snap_value,
    output logic [CNT_W-1:0]     timeout_count,
    output logic                 busy,
    input  logic                 timer_irq,
    timer_ctrl_master_if.master  avm
);

    state_t      state, next;
    logic [31:0] period;
    logic        cont;
    logic [15:0] snap_lo;
    logic [2:0]  addr;
    logic [15:0] wdata;
    logic        rd, wr, accept, acc;

    assign cmd_ready  = reset_n && state == IDLE && !timer_irq;
    assign accept     = cmd_valid && cmd_ready;
    assign acc        = !avm.waitrequest;
    assign busy       = state != IDLE;
    assign snap_valid = state == SNAP_DONE;

    always_ff @(posedge clk) begin
        if (!reset_n) state <= IDLE;
        else          state <= next;
    end

    // irq wins over a pending command because cmd_ready already excludes it
    always_comb begin
        next = state;
        case (state)
            IDLE:      next = timer_irq ? CLR_ST : !accept ? IDLE :
                              cmd_op == OP_START ? WR_PL : cmd_op == OP_STOP ? WR_STOP :
                              cmd_op == OP_SNAP ? WR_SNAP : IDLE;
            WR_PL:     next = acc ? WR_PH : WR_PL;
            WR_PH:     next = acc ? WR_CTRL : WR_PH;
            WR_CTRL:   next = acc ? IDLE : WR_CTRL;
            WR_STOP:   next = acc ? IDLE : WR_STOP;
            WR_SNAP:   next = acc ? RD_SL : WR_SNAP;
            RD_SL:     next = acc ? WAIT_SL : RD_SL;
            WAIT_SL:   next = avm.readdatavalid ? RD_SH : WAIT_SL;
            RD_SH:     next = acc ? WAIT_SH : RD_SH;
            WAIT_SH:   next = avm.readdatavalid ? SNAP_DONE : WAIT_SH;
            SNAP_DONE: next = IDLE;
            CLR_ST:    next = acc ? IRQ_HOLD : CLR_ST;
            IRQ_HOLD:  next = IDLE;
            default:   next = IDLE;
        endcase
    end

    always_comb begin
        addr  = TMR_STATUS;
        wdata = '0;
        rd    = 1'b0;
        wr    = 1'b0;
        case (state)
            WR_PL:   begin addr = TMR_PERIOD_L; wdata = period[15:0];  wr = 1'b1; end
            WR_PH:   begin addr = TMR_PERIOD_H; wdata = period[31:16]; wr = 1'b1; end
            WR_CTRL: begin
                addr  = TMR_CONTROL;
                wdata = (16'(1) << START) | (16'(cont) << CONT) | (16'(1) << ITO);
                wr    = 1'b1;
            end
            WR_STOP: begin addr = TMR_CONTROL; wdata = (16'(1) << STOP) | (16'(1) << ITO); wr = 1'b1; end
            WR_SNAP: begin addr = TMR_SNAP_L; wr = 1'b1; end
            RD_SL:   begin addr = TMR_SNAP_L; rd = 1'b1; end
            RD_SH:   begin addr = TMR_SNAP_H; rd = 1'b1; end
            CLR_ST:  begin addr = TMR_STATUS; wr = 1'b1; end
            default: ;
        endcase
    end

    assign avm.address   = ADDR_W'(addr);
    assign avm.writedata = wdata;
    assign avm.read      = rd;
    assign avm.write     = wr;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            period        <= '0;
            cont          <= 1'b0;
            snap_lo       <= '0;
            snap_value    <= '0;
            timeout_count <= '0;
        end else begin
            if (accept) begin
                period <= cmd_period;
                cont   <= cmd_continuous;
            end
            if (state == WAIT_SL && avm.readdatavalid) snap_lo <= avm.readdata;
            if (state == WAIT_SH && avm.readdatavalid) snap_value <= {avm.readdata, snap_lo};
            if (state == CLR_ST && acc && ~&timeout_count) timeout_count <= timeout_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_timer_ctrl_master.sv
// tb_timer_ctrl_master: random commands and irqs against a behavioural timer slave and a transaction-level reference
module tb_timer_ctrl_master;

    localparam int CW = 4;
    localparam logic [CW-1:0] CMAX = '1;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          cmd_valid = 1'b0;
    logic [1:0]    cmd_op = '0;
    logic [31:0]   cmd_period = '0;
    logic          cmd_continuous = 1'b0;
    logic          timer_irq = 1'b0;
    logic          cmd_ready, snap_valid, busy;
    logic [31:0]   snap_value;
    logic [CW-1:0] timeout_count;

    timer_ctrl_master_if #(.ADDR_W(3)) bus ();

    timer_ctrl_master #(.CNT_W(CW), .ADDR_W(3)) dut (
        .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_period(cmd_period), .cmd_continuous(cmd_continuous),
        .snap_valid(snap_valid), .snap_value(snap_value), .timeout_count(timeout_count),
        .busy(busy), .timer_irq(timer_irq), .avm(bus.master)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_err = 0;
    logic [31:0] tmr_count = '0;
    int force_stall = 0, lat_force = 1, irq_raise = 0;
    logic [CW-1:0] ref_cnt = '0;

    logic [31:0] snap_reg = '0, snap_last = '0;
    logic [15:0] pend_data = '0;
    logic [19:0] held = '0, cur;
    logic        stalled = 1'b0;
    int pend_lat = 0, drop_cnt = 0, stall_left = 0, stall_tot = 0, lat_tot = 0, snap_cnt = 0;
    int bad_rw = 0, bad_rdy = 0, bad_hold = 0, raise_seen = 0;
    logic [19:0] got_q[$];

    function automatic logic [19:0] tx(input logic w, input logic [2:0] a, input logic [15:0] d);
        return {w, a, d};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // timer slave: random stalls, variable read latency, irq that drops one cycle after the clear write
    always @(negedge clk) begin
        if (bus.read && bus.write) bad_rw++;
        if (cmd_ready !== (reset_n && !busy && !timer_irq)) bad_rdy++;
        if (snap_valid) begin
            snap_cnt++;
            snap_last = snap_value;
        end
        bus.readdatavalid = 1'b0;
        if (pend_lat > 0) begin
            pend_lat--;
            if (pend_lat == 0) begin
                bus.readdatavalid = 1'b1;
                bus.readdata = pend_data;
            end
        end
        if (drop_cnt > 0) begin
            drop_cnt--;
            if (drop_cnt == 0) timer_irq = 1'b0;
        end
        if (irq_raise != raise_seen) begin
            raise_seen = irq_raise;
            timer_irq = 1'b1;
        end
        bus.waitrequest = 1'b0;
        if (!reset_n || !(bus.read || bus.write)) stalled = 1'b0;
        else begin
            cur = {bus.write, bus.address, bus.write ? bus.writedata : 16'h0};
            if (stalled && cur !== held) bad_hold++;
            if (!stalled)
                stall_left = force_stall >= 0 ? force_stall :
                             ($urandom_range(0, 3) == 0 ? int'($urandom_range(1, 2)) : 0);
            if (stall_left > 0) begin
                stall_left--;
                stall_tot++;
                stalled = 1'b1;
                held = cur;
                bus.waitrequest = 1'b1;
            end else begin
                stalled = 1'b0;
                got_q.push_back(cur);
                if (cur[19]) begin
                    if (bus.address == 3'd4) snap_reg = tmr_count;
                    if (bus.address == 3'd0) drop_cnt = 2;
                end else begin
                    pend_lat = lat_force > 0 ? lat_force : int'($urandom_range(1, 3));
                    lat_tot += pend_lat;
                    pend_data = bus.address == 3'd4 ? snap_reg[15:0] : snap_reg[31:16];
                end
            end
        end
    end

    task automatic do_cmd(input int op, input logic [31:0] per, input logic c, input int irq_at);
        logic [19:0] exp_q[$];
        logic [31:0] exp_snap;
        int base, s0, l0, sn0, n, cyc, want;
        base = got_q.size();
        s0 = stall_tot;
        l0 = lat_tot;
        sn0 = snap_cnt;
        exp_snap = tmr_count;
        if (op == 0) begin
            exp_q.push_back(tx(1, 2, per[15:0]));
            exp_q.push_back(tx(1, 3, per[31:16]));
            exp_q.push_back(tx(1, 1, c ? 16'h0007 : 16'h0005));
        end else if (op == 1) exp_q.push_back(tx(1, 1, 16'h0009));
        else if (op == 2) begin
            exp_q.push_back(tx(1, 4, 16'h0));
            exp_q.push_back(tx(0, 4, 16'h0));
            exp_q.push_back(tx(0, 5, 16'h0));
        end
        cmd_op = 2'(op);
        cmd_period = per;
        cmd_continuous = c;
        cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
        chk("cmd_accept", 32'(n < 50), 1);
        @(negedge clk);
        cmd_valid = 1'b0;
        cyc = 0;
        while (busy && cyc < 300) begin
            cyc++;
            if (cyc == irq_at) irq_raise++;
            @(negedge clk);
        end
        chk("busy_end", 32'(cyc < 300), 1);
        if (irq_at > 0) begin
            n = 0;
            while ((busy || timer_irq) && n < 100) begin @(negedge clk); n++; end
            chk("irq_end", 32'(n < 100), 1);
            exp_q.push_back(tx(1, 0, 16'h0));
            if (ref_cnt != CMAX) ref_cnt++;
        end else begin
            want = exp_q.size() + (stall_tot - s0) + (lat_tot - l0) + (op == 2 ? 1 : 0);
            chk("busy_cycles", cyc, want);
        end
        chk("ntxn", got_q.size() - base, exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            chk($sformatf("txn%0d_op%0d", i, op),
                base + i < got_q.size() ? 32'(got_q[base + i]) : 32'hFFFF_FFFF, 32'(exp_q[i]));
        if (op == 2) begin
            chk("snap_pulses", snap_cnt - sn0, 1);
            chk("snap_pulse_val", snap_last, exp_snap);
            chk("snap_held", snap_value, exp_snap);
        end else chk("no_snap_pulse", snap_cnt - sn0, 0);
        chk("timeout_count", 32'(timeout_count), 32'(ref_cnt));
        chk("ready_idle", 32'(cmd_ready), 1);
    endtask

    task automatic do_irq();
        int base, n;
        base = got_q.size();
        n = 0;
        irq_raise++;
        while (!busy && n < 10) begin @(negedge clk); n++; end
        while ((busy || timer_irq) && n < 100) begin @(negedge clk); n++; end
        chk("irq_done", 32'(n < 100), 1);
        if (ref_cnt != CMAX) ref_cnt++;
        chk("irq_ntxn", got_q.size() - base, 1);
        if (got_q.size() > base) chk("irq_txn", 32'(got_q[base]), 32'(tx(1, 0, 16'h0)));
        chk("irq_count", 32'(timeout_count), 32'(ref_cnt));
    endtask

    initial begin
        int n, sn0, base, r;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_ready", 32'(cmd_ready), 0);
        chk("rst_count", 32'(timeout_count), 0);
        chk("rst_snap", snap_value, 0);
        chk("rst_write", 32'(bus.write), 0);
        reset_n = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", 32'(cmd_ready), 1);
        force_stall = 0;
        lat_force = 1;
        do_cmd(0, 32'h0001_86A0, 1'b1, 0);
        force_stall = 2;
        do_cmd(0, 32'h1234_0042, 1'b0, 0);
        force_stall = 0;
        tmr_count = 32'h0012_3456;
        do_cmd(2, 32'h0, 1'b0, 0);
        tmr_count = 32'hABCD_0001;
        do_cmd(2, 32'h0, 1'b0, 2);
        do_cmd(1, 32'h0, 1'b0, 0);
        do_cmd(3, 32'h5555_AAAA, 1'b1, 0);
        force_stall = -1;
        lat_force = 0;
        for (int k = 0; k < 40; k++) begin
            r = int'($urandom_range(0, 4));
            if (r == 4) do_irq();
            else begin
                if (r == 2) tmr_count = $urandom;
                do_cmd(r, $urandom, 1'($urandom_range(0, 1)), 0);
            end
        end
        for (int k = 0; k < 18; k++) do_irq();
        chk("saturated", 32'(timeout_count), 32'(CMAX));
        force_stall = 0;
        lat_force = 6;
        tmr_count = 32'hCAFE_F00D;
        sn0 = snap_cnt;
        base = got_q.size();
        cmd_op = 2'd2;
        cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
        @(negedge clk);
        cmd_valid = 1'b0;
        while (got_q.size() < base + 3 && n < 100) begin @(negedge clk); n++; end
        chk("reach_wait_sh", 32'(n < 100), 1);
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_ready", 32'(cmd_ready), 0);
        chk("mid_rst_read", 32'(bus.read), 0);
        chk("mid_rst_write", 32'(bus.write), 0);
        chk("mid_rst_addr", 32'(bus.address), 0);
        chk("mid_rst_wdata", 32'(bus.writedata), 0);
        chk("mid_rst_count", 32'(timeout_count), 0);
        chk("mid_rst_snap", snap_value, 0);
        chk("mid_rst_snapv", 32'(snap_valid), 0);
        reset_n = 1'b1;
        ref_cnt = '0;
        @(negedge clk);
        chk("ready_after_mid_rst", 32'(cmd_ready), 1);
        repeat (8) @(negedge clk);
        chk("late_rdv_ignored", snap_cnt - sn0, 0);
        chk("late_rdv_idle", 32'(busy), 0);
        chk("late_rdv_snap", snap_value, 0);
        chk("rw_overlap", bad_rw, 0);
        chk("ready_rule", bad_rdy, 0);
        chk("hold_stable", bad_hold, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
